// File: rtl/issue_unit_pkg.sv
// Shared issue-stage types: queue identifiers and CDB reservation slots.
// No logic; no latency or backpressure.
package issue_unit_pkg;

  typedef enum logic [1:0] {
    INT_FIFO   = 2'd0,
    LD_ST_FIFO = 2'd1,
    MULT_FIFO  = 2'd2,
    DIV_FIFO   = 2'd3
  } fifo_data_type;

  typedef struct packed {
    logic          valid;
    fifo_data_type owner;
  } cdb_slot_t;

  localparam int MAX_EXEC_LAT = 15;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/issue_unit_rr_arb.sv
// 4-way round-robin grant; grant is combinational, pointer is registered.
// Search starts after the last winner; pointer holds when nothing is granted.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt
);
  import issue_unit_pkg::*;

  logic [1:0] last_q;
  logic [1:0] gnt_idx;
  logic [1:0] idx;
  logic       gnt_any;

  always_comb begin
    gnt     = '0;
    gnt_idx = last_q;
    gnt_any = 1'b0;
    idx     = last_q;
    // k = 4 wraps back onto the previous winner, so it is considered last.
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= DIV_FIFO;
    end else if (gnt_any) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/issue_unit.sv
// Picks one issue queue per cycle so no two results collide on the CDB; grant is same-cycle.
// A ready queue blocked by a slot conflict or busy divider simply retries next cycle.
module issue_unit #(
  parameter int INT_LAT  = 1,
  parameter int LDST_LAT = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       int_issue_rdy,
  input  logic       ldst_issue_rdy,
  input  logic       mult_issue_rdy,
  input  logic       div_issue_rdy,
  output logic       int_issue_en,
  output logic       ldst_issue_en,
  output logic       mult_issue_en,
  output logic       div_issue_en,
  output logic [1:0] cdb_owner,
  output logic       cdb_owner_valid,
  output logic       div_busy
);
  import issue_unit_pkg::*;

  localparam int D = max2(max2(INT_LAT, LDST_LAT), max2(MULT_LAT, DIV_LAT));

  function automatic int unit_lat(input int u);
    case (u)
      0:       return INT_LAT;
      1:       return LDST_LAT;
      2:       return MULT_LAT;
      default: return DIV_LAT;
    endcase
  endfunction

  function automatic int wr_slot(input int u);
    return (unit_lat(u) > 1) ? unit_lat(u) - 1 : 1;
  endfunction

  cdb_slot_t  tbl_q   [1:D];
  cdb_slot_t  tbl_nxt [1:D];
  cdb_slot_t  cdb_q;
  cdb_slot_t  cdb_nxt;
  logic [3:0] div_cnt_q;
  logic [3:0] div_cnt_nxt;
  logic [3:0] rdy;
  logic [3:0] req;
  logic [3:0] gnt;

  assign rdy = {div_issue_rdy, mult_issue_rdy, ldst_issue_rdy, int_issue_rdy};

  // A unit may issue only if the CDB slot its result will land in is still free.
  always_comb begin
    req = '0;
    for (int u = 0; u < 4; u++) begin
      req[u] = rst_n && !flush && rdy[u] && !tbl_q[unit_lat(u)].valid;
    end
    if (div_cnt_q != 4'd0) req[3] = 1'b0;
  end

  rr_arbiter4 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    for (int i = 1; i < D; i++) tbl_nxt[i] = tbl_q[i+1];
    tbl_nxt[D] = '0;
    cdb_nxt    = tbl_q[1];
    for (int u = 0; u < 4; u++) begin
      if (gnt[u]) begin
        if (unit_lat(u) == 1) cdb_nxt = '{valid: 1'b1, owner: fifo_data_type'(u[1:0])};
        else tbl_nxt[wr_slot(u)] = '{valid: 1'b1, owner: fifo_data_type'(u[1:0])};
      end
    end
    div_cnt_nxt = div_cnt_q;
    if (gnt[3])                   div_cnt_nxt = 4'(DIV_LAT - 1);
    else if (div_cnt_q != 4'd0)   div_cnt_nxt = div_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= D; i++) tbl_q[i] <= '0;
      cdb_q     <= '{valid: 1'b0, owner: INT_FIFO};
      div_cnt_q <= '0;
    end else if (flush) begin
      for (int i = 1; i <= D; i++) tbl_q[i] <= '0;
      cdb_q.valid <= 1'b0;
      div_cnt_q   <= '0;
    end else begin
      tbl_q     <= tbl_nxt;
      cdb_q     <= cdb_nxt;
      div_cnt_q <= div_cnt_nxt;
    end
  end

  assign int_issue_en    = gnt[0];
  assign ldst_issue_en   = gnt[1];
  assign mult_issue_en   = gnt[2];
  assign div_issue_en    = gnt[3];
  assign cdb_owner       = cdb_q.owner;
  assign cdb_owner_valid = cdb_q.valid;
  assign div_busy        = (div_cnt_q != 4'd0);

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: stimulus pushes expected grants/broadcasts, a monitor pops and compares.
module tb_issue_unit;
  import issue_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       int_issue_rdy = 1'b0, ldst_issue_rdy = 1'b0, mult_issue_rdy = 1'b0, div_issue_rdy = 1'b0;
  logic       int_issue_en, ldst_issue_en, mult_issue_en, div_issue_en;
  logic [1:0] cdb_owner;
  logic       cdb_owner_valid;
  logic       div_busy;

  localparam logic [3:0] R_INT = 4'b0001, R_LDST = 4'b0010, R_MULT = 4'b0100, R_DIV = 4'b1000;

  issue_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .int_issue_rdy   (int_issue_rdy),
    .ldst_issue_rdy  (ldst_issue_rdy),
    .mult_issue_rdy  (mult_issue_rdy),
    .div_issue_rdy   (div_issue_rdy),
    .int_issue_en    (int_issue_en),
    .ldst_issue_en   (ldst_issue_en),
    .mult_issue_en   (mult_issue_en),
    .div_issue_en    (div_issue_en),
    .cdb_owner       (cdb_owner),
    .cdb_owner_valid (cdb_owner_valid),
    .div_busy        (div_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;
  bit mon_en = 1'b0;
  int exp_gnt[$];
  int exp_cdb[$];

  // All-four-ready run: grant unit per cycle 0..13, then broadcast cycle/unit pairs.
  int g2_u   [14] = '{0, 1, 2, 3, 0, 2, 0, 1, 2, 0, 2, 3, 0, 2};
  int c2_cyc [14] = '{1, 2, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 17, 19};
  int c2_u   [14] = '{0, 1, 0, 2, 0, 1, 2, 0, 3, 2, 0, 2, 2, 3};

  function automatic int enc(input int rel, input int u);
    return rel * 4 + u;
  endfunction

  function automatic int g2idx(input logic [3:0] g);
    return g[0] ? 0 : g[1] ? 1 : g[2] ? 2 : 3;
  endfunction

  // Monitor: every presented grant / broadcast must match the head of its queue.
  logic [3:0] m_g;
  int         m_rel, m_exp, m_act;
  always @(negedge clk) begin
    if (mon_en) begin
      m_g   = {div_issue_en, mult_issue_en, ldst_issue_en, int_issue_en};
      m_rel = cyc - base;
      if (m_g != 4'b0000) begin
        tests++;
        if ($countones(m_g) != 1) begin
          fails++;
          $display("FAIL grant_onehot @%0d: got %b, required one-hot", m_rel, m_g);
        end
        tests++;
        m_act = enc(m_rel, g2idx(m_g));
        if (exp_gnt.size() == 0) begin
          fails++;
          $display("FAIL grant_unexpected @%0d: got unit %0d, required no grant", m_rel, g2idx(m_g));
        end else begin
          m_exp = exp_gnt.pop_front();
          if (m_act != m_exp) begin
            fails++;
            $display("FAIL grant @%0d: got unit %0d @%0d, required unit %0d @%0d",
                     m_rel, m_act % 4, m_act / 4, m_exp % 4, m_exp / 4);
          end
        end
      end
      if (cdb_owner_valid) begin
        tests++;
        m_act = enc(m_rel, int'(cdb_owner));
        if (exp_cdb.size() == 0) begin
          fails++;
          $display("FAIL cdb_unexpected @%0d: got owner %0d, required no broadcast", m_rel, cdb_owner);
        end else begin
          m_exp = exp_cdb.pop_front();
          if (m_act != m_exp) begin
            fails++;
            $display("FAIL cdb @%0d: got owner %0d @%0d, required owner %0d @%0d",
                     m_rel, m_act % 4, m_act / 4, m_exp % 4, m_exp / 4);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {div_issue_rdy, mult_issue_rdy, ldst_issue_rdy, int_issue_rdy} = r;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0d: got %0h, required %0h", name, cyc - base, act, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({int_issue_en, ldst_issue_en, mult_issue_en, div_issue_en,
                 cdb_owner, cdb_owner_valid, div_busy});
  endfunction

  task automatic drain(input string name);
    check({name, "_grants_missing"}, exp_gnt.size(), 0);
    check({name, "_cdb_missing"}, exp_cdb.size(), 0);
  endtask

  task automatic start_test();
    mon_en = 1'b0;
    set_rdy(4'b0000);
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    exp_gnt.delete();
    exp_cdb.delete();
    base   = cyc;
    mon_en = 1'b1;
  endtask

  initial begin
    // Reset values, then idle with nothing ready.
    #2;
    check("reset_outputs", out_vec(), 0);
    start_test();
    for (int c = 0; c < 20; c++) begin
      check("idle_outputs", out_vec(), 0);
      tick();
    end
    drain("idle");

    // All four queues ready.
    start_test();
    for (int i = 0; i < 14; i++) exp_gnt.push_back(enc(i, g2_u[i]));
    for (int i = 0; i < 14; i++) exp_cdb.push_back(enc(c2_cyc[i], c2_u[i]));
    for (int c = 0; c <= 20; c++) begin
      set_rdy(c < 14 ? 4'b1111 : 4'b0000);
      tick();
    end
    drain("all_ready");

    // Slot conflict: INT blocked at 3 by the MULT result due at 4.
    start_test();
    exp_gnt.push_back(enc(0, 2));
    exp_gnt.push_back(enc(4, 0));
    exp_cdb.push_back(enc(4, 2));
    exp_cdb.push_back(enc(5, 0));
    for (int c = 0; c <= 7; c++) begin
      set_rdy((c == 0 ? R_MULT : 4'b0000) | ((c == 3 || c == 4) ? R_INT : 4'b0000));
      tick();
    end
    drain("slot_conflict");

    // Divider occupancy: back-to-back divides every DIV_LAT cycles.
    start_test();
    foreach (g2_u[i]) if (i < 3) begin
      exp_gnt.push_back(enc(i * 8, 3));
      exp_cdb.push_back(enc(i * 8 + 8, 3));
    end
    for (int c = 0; c <= 25; c++) begin
      set_rdy(c <= 16 ? R_DIV : 4'b0000);
      check("div_busy", int'(div_busy), int'(c >= 1 && c <= 23 && (c % 8) != 0));
      tick();
    end
    drain("divider");

    // Flush at 2 squashes the MULT and DIV in flight and blocks the INT request.
    start_test();
    exp_gnt.push_back(enc(0, 2));
    exp_gnt.push_back(enc(1, 3));
    for (int c = 0; c <= 10; c++) begin
      set_rdy(c == 0 ? R_MULT : c == 1 ? R_DIV : c == 2 ? R_INT : 4'b0000);
      flush = (c == 2);
      check("flush_div_busy", int'(div_busy), int'(c == 2));
      tick();
    end
    flush = 1'b0;
    drain("flush_early");

    // Flush while the MULT result sits in the last slot suppresses its broadcast.
    start_test();
    exp_gnt.push_back(enc(0, 2));
    for (int c = 0; c <= 7; c++) begin
      set_rdy(c == 0 ? R_MULT : 4'b0000);
      flush = (c == 3);
      tick();
    end
    flush = 1'b0;
    drain("flush_queued");

    // Asynchronous reset with a divide in flight.
    start_test();
    exp_gnt.push_back(enc(0, 3));
    for (int c = 0; c <= 2; c++) begin
      set_rdy(c == 0 ? R_DIV : 4'b0000);
      tick();
    end
    check("pre_reset_div_busy", int'(div_busy), 1);
    drain("pre_reset");
    #2;
    mon_en = 1'b0;
    set_rdy(R_INT);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 0);
    tick();
    rst_n = 1'b1;
    exp_gnt.delete();
    exp_cdb.delete();
    base = cyc;
    exp_gnt.push_back(enc(0, 0));
    exp_gnt.push_back(enc(1, 2));
    exp_cdb.push_back(enc(1, 0));
    exp_cdb.push_back(enc(5, 2));
    mon_en = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      set_rdy(c <= 1 ? (R_INT | R_MULT) : 4'b0000);
      tick();
    end
    drain("post_reset");
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
